bcd_entry_display: RTL and testbench
====================================

Name: bcd_entry_display

Overview:
- Reader side of the three-digit BCD entry protocol: one nibble per commit strobe, ones digit first, then tens, then hundreds.
- Tracks which digit position is expected next and latches each committed nibble into a 12-bit BCD value.
- Drives HEX0-HEX3 so the digit awaiting entry flashes, completed digits show steady, and HEX3 shows the sign.
- Sits between the debounced KEY/SW front end and the seven-segment pins.

Parameters:
- FLASH_DIV, 25000000, clock cycles per flash half-period (1 Hz blink at 50 MHz); legal range >= 2.

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous reset, active-low.
- start  in  1  single-cycle pulse: begin a new entry, clear value.
- sign_in  in  1  sign latched on start (1 = negative).
- digit_we  in  1  single-cycle pulse: commit digit_in to the expected position.
- digit_in  in  4  BCD digit being committed.
- track_inp  out  2  expected position: 0 = none/idle, 1 = ones, 2 = tens, 3 = hundreds.
- value_out  out  12  latched BCD value {huns, tens, ones}.
- value_valid  out  1  high while all three digits are committed.
- digit_err  out  1  one-cycle pulse when a commit is rejected (digit_in > 9).
- HEX0  out  7  ones digit, segments {g,f,e,d,c,b,a}, active-low.
- HEX1  out  7  tens digit, same encoding.
- HEX2  out  7  hundreds digit, same encoding.
- HEX3  out  7  sign: 7'b0111111 ('-') if negative, else 7'b1111111.

Behaviour:
- All outputs are registered. Every effect appears on outputs on the clock edge after the causing input is sampled.
- Reset (reset_n = 0 at a clock edge, regardless of state) produces:
  - state IDLE, track_inp = 0;
  - value_out = 12'h000, value_valid = 0, digit_err = 0, sign register = 0;
  - flash counter = 0, flash phase = 0;
  - HEX0-HEX2 = 7'b1000000 ('0'), HEX3 = 7'b1111111.
- States and transitions:
  - IDLE: track_inp = 0. digit_we is ignored. start -> ONES.
  - ONES: track_inp = 1. Valid digit_we writes value[3:0] -> TENS.
  - TENS: track_inp = 2. Valid digit_we writes value[7:4] -> HUNS.
  - HUNS: track_inp = 3. Valid digit_we writes value[11:8] -> SHOW.
  - SHOW: track_inp = 0, value_valid = 1. digit_we is ignored.
- start in any non-reset state:
  - clears value_out to 0 and value_valid to 0;
  - latches sign_in;
  - goes to ONES.
- start and digit_we asserted in the same cycle: start wins and the digit is discarded.
- A commit with digit_in > 9:
  - value and state are unchanged;
  - digit_err pulses high for exactly one cycle.
- digit_we asserted for several consecutive cycles counts as one commit per cycle. The front end guarantees single-cycle pulses.
- Flash timer:
  - counter counts 0 to FLASH_DIV-1, then wraps to 0 and toggles the flash phase;
  - counter and phase are forced to 0 on every state transition, so a newly expected digit is lit for a full half-period first;
  - the timer runs only in ONES, TENS and HUNS.
- Display:
  - each HEX digit shows the stored nibble, decoded with the standard 0-9 table (0 = 7'b1000000 ... 9 = 7'b0010000);
  - the digit at the expected position shows 7'b1111111 (blank) while flash phase = 1;
  - digits not yet entered show '0'.
- Wrap-around: a start after SHOW begins a fresh entry. The previous value is lost in the same cycle.

Test Plan:
1. Reset, then start with sign_in = 0 and commit 3, 2, 1 (FLASH_DIV = 4) -> value_out = 12'h123, value_valid = 1 one cycle after the third commit, track_inp sequence 1, 2, 3, 0, HEX2/1/0 = '1', '2', '3', HEX3 blank.
2. Start with sign_in = 1, commit 5 then 7, then hold 40 cycles -> HEX0 = '5', HEX1 = '7' steady, HEX2 alternates '0'/blank every 4 cycles starting lit, HEX3 = '-'.
3. After 12'h875 is complete, assert start -> value_out = 0, value_valid = 0, track_inp = 1; then commit 0, 4, 4 -> value_out = 12'h440.
4. In TENS, commit digit_in = 4'hB -> digit_err pulses once, value and track_inp unchanged; then commit 6 -> accepted into the tens position.
5. Assert start and digit_we together in HUNS -> track_inp = 1, value_out = 0, and the digit is not stored.
6. Assert reset_n = 0 for one cycle mid-entry in TENS -> all outputs at their reset values; digit_we in IDLE afterwards has no effect.

Source files
------------

// File: rtl/bcd_entry_display.sv
// bcd_entry_display
//   Reader side of a three-digit BCD entry protocol. Digits arrive one per
//   digit_we strobe, ones first, then tens, then hundreds. The position
//   awaiting entry flashes on the seven-segment display, committed digits
//   show steady, and HEX3 shows the sign latched at start.
//
// Ports
//   CLOCK_50     in   system clock, rising edge
//   reset_n      in   synchronous reset, active-low
//   start        in   pulse: begin a new entry, clear value, latch sign_in
//   sign_in      in   sign for the new entry (1 = negative)
//   digit_we     in   pulse: commit digit_in to the expected position
//   digit_in     in   BCD digit being committed
//   track_inp    out  expected position: 0 none, 1 ones, 2 tens, 3 hundreds
//   value_out    out  latched BCD value {huns, tens, ones}
//   value_valid  out  high while all three digits are committed
//   digit_err    out  one-cycle pulse when a commit is rejected (> 9)
//   HEX0..HEX2   out  ones/tens/hundreds digit, {g,f,e,d,c,b,a} active-low
//   HEX3         out  sign: '-' when negative, blank otherwise
module bcd_entry_display #(
   parameter int FLASH_DIV = 25000000
) (
   input  logic        CLOCK_50,
   input  logic        reset_n,
   input  logic        start,
   input  logic        sign_in,
   input  logic        digit_we,
   input  logic [3:0]  digit_in,
   output logic [1:0]  track_inp,
   output logic [11:0] value_out,
   output logic        value_valid,
   output logic        digit_err,
   output logic [6:0]  HEX0,
   output logic [6:0]  HEX1,
   output logic [6:0]  HEX2,
   output logic [6:0]  HEX3
);

   localparam int CW = $clog2(FLASH_DIV);
   localparam logic [CW-1:0] CNT_MAX = CW'(FLASH_DIV - 1);
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;

   typedef enum logic [2:0] {S_IDLE, S_ONES, S_TENS, S_HUNS, S_SHOW} state_t;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = SEG_BLANK;
      endcase
   endfunction

   state_t        state_q, state_d;
   logic [11:0]   value_q, value_d;
   logic          sign_q, sign_d;
   logic          err_q, err_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          phase_q, phase_d;
   logic [1:0]    track_q, track_d;
   logic          valid_q, valid_d;
   logic [6:0]    hex0_q, hex0_d;
   logic [6:0]    hex1_q, hex1_d;
   logic [6:0]    hex2_q, hex2_d;
   logic [6:0]    hex3_q, hex3_d;
   logic          entering;
   logic          restart;

   always_comb begin
      state_d  = state_q;
      value_d  = value_q;
      sign_d   = sign_q;
      err_d    = 1'b0;
      cnt_d    = cnt_q;
      phase_d  = phase_q;
      track_d  = 2'd0;
      entering = (state_q == S_ONES) || (state_q == S_TENS) || (state_q == S_HUNS);

      // start has priority over a simultaneous commit, which is discarded
      if (start) begin
         state_d = S_ONES;
         value_d = 12'h000;
         sign_d  = sign_in;
      end else if (digit_we && entering) begin
         if (digit_in > 4'd9) begin
            err_d = 1'b1;
         end else begin
            case (state_q)
               S_ONES: begin value_d[3:0]  = digit_in; state_d = S_TENS; end
               S_TENS: begin value_d[7:4]  = digit_in; state_d = S_HUNS; end
               S_HUNS: begin value_d[11:8] = digit_in; state_d = S_SHOW; end
               default: ;
            endcase
         end
      end

      // A restart (including start while already in ONES) relights the
      // newly expected digit for a full half-period before it blanks.
      restart = start || (state_d != state_q);
      if (restart) begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end else if (entering) begin
         if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end

      case (state_d)
         S_ONES:  track_d = 2'd1;
         S_TENS:  track_d = 2'd2;
         S_HUNS:  track_d = 2'd3;
         default: track_d = 2'd0;
      endcase
      valid_d = (state_d == S_SHOW);

      // Outputs are registered from next-state values so every effect is
      // visible on the edge that samples its cause.
      hex0_d = (phase_d && track_d == 2'd1) ? SEG_BLANK : seg7(value_d[3:0]);
      hex1_d = (phase_d && track_d == 2'd2) ? SEG_BLANK : seg7(value_d[7:4]);
      hex2_d = (phase_d && track_d == 2'd3) ? SEG_BLANK : seg7(value_d[11:8]);
      hex3_d = sign_d ? SEG_MINUS : SEG_BLANK;
   end

   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         value_q <= 12'h000;
         sign_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         phase_q <= 1'b0;
         track_q <= 2'd0;
         valid_q <= 1'b0;
         hex0_q  <= 7'b1000000;
         hex1_q  <= 7'b1000000;
         hex2_q  <= 7'b1000000;
         hex3_q  <= SEG_BLANK;
      end else begin
         state_q <= state_d;
         value_q <= value_d;
         sign_q  <= sign_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         track_q <= track_d;
         valid_q <= valid_d;
         hex0_q  <= hex0_d;
         hex1_q  <= hex1_d;
         hex2_q  <= hex2_d;
         hex3_q  <= hex3_d;
      end
   end

   assign track_inp   = track_q;
   assign value_out   = value_q;
   assign value_valid = valid_q;
   assign digit_err   = err_q;
   assign HEX0        = hex0_q;
   assign HEX1        = hex1_q;
   assign HEX2        = hex2_q;
   assign HEX3        = hex3_q;

endmodule

// File: tb/tb_bcd_entry_display.sv
module tb_bcd_entry_display;

   localparam int FD = 4;

   logic        CLOCK_50 = 1'b0;
   logic        reset_n  = 1'b0;
   logic        start    = 1'b0;
   logic        sign_in  = 1'b0;
   logic        digit_we = 1'b0;
   logic [3:0]  digit_in = 4'd0;
   logic [1:0]  track_inp;
   logic [11:0] value_out;
   logic        value_valid;
   logic        digit_err;
   logic [6:0]  HEX0, HEX1, HEX2, HEX3;

   int checks = 0;
   int errors = 0;

   bcd_entry_display #(.FLASH_DIV(FD)) dut (
      .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start), .sign_in(sign_in),
      .digit_we(digit_we), .digit_in(digit_in), .track_inp(track_inp),
      .value_out(value_out), .value_valid(value_valid), .digit_err(digit_err),
      .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   localparam logic [6:0] BLK = 7'b1111111;
   localparam logic [6:0] MIN = 7'b0111111;
   logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};

   // ---------------- behavioural model ----------------
   // active: an entry has been started; entered: how many digits are in.
   bit armed = 0;
   bit m_active = 0;
   int m_entered = 0;
   int m_dig [3] = '{0, 0, 0};
   bit m_sign = 0;
   bit m_err = 0;
   int m_tmr = 0;
   bit m_ph = 0;

   function automatic logic [1:0] exp_track();
      return (m_active && m_entered < 3) ? 2'(m_entered + 1) : 2'd0;
   endfunction

   function automatic logic [6:0] exp_hex(input int i);
      if (m_active && m_entered < 3 && m_entered == i && m_ph) return BLK;
      return seg_tab[m_dig[i]];
   endfunction

   task automatic cmp(input string name, input logic [11:0] got, input logic [11:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
      end
   endtask

   always @(posedge CLOCK_50) begin
      bit restart;
      restart = 0;
      if (!reset_n) begin
         armed = 1; m_active = 0; m_entered = 0; m_dig = '{0, 0, 0};
         m_sign = 0; m_err = 0; m_tmr = 0; m_ph = 0;
      end else begin
         m_err = 0;
         if (start) begin
            m_active = 1; m_entered = 0; m_dig = '{0, 0, 0};
            m_sign = sign_in; restart = 1;
         end else if (digit_we && m_active && m_entered < 3) begin
            if (digit_in <= 9) begin
               m_dig[m_entered] = int'(digit_in);
               m_entered++;
               restart = 1;
            end else m_err = 1;
         end
         if (restart) begin
            m_tmr = 0; m_ph = 0;
         end else if (m_active && m_entered < 3) begin
            m_tmr++;
            if (m_tmr == FD) begin m_tmr = 0; m_ph = ~m_ph; end
         end
      end
      #1;
      if (armed) begin
         cmp("track",  12'(track_inp), 12'(exp_track()));
         cmp("value",  value_out, 12'(m_dig[2] * 256 + m_dig[1] * 16 + m_dig[0]));
         cmp("valid",  12'(value_valid), 12'(m_active && m_entered == 3));
         cmp("err",    12'(digit_err), 12'(m_err));
         cmp("hex0",   12'(HEX0), 12'(exp_hex(0)));
         cmp("hex1",   12'(HEX1), 12'(exp_hex(1)));
         cmp("hex2",   12'(HEX2), 12'(exp_hex(2)));
         cmp("hex3",   12'(HEX3), 12'(m_sign ? MIN : BLK));
      end
   end

   // ---------------- directed and random stimulus ----------------
   task automatic step(input bit s, input bit sg, input bit we, input logic [3:0] d, input bit rn);
      @(negedge CLOCK_50);
      start = s; sign_in = sg; digit_we = we; digit_in = d; reset_n = rn;
      @(posedge CLOCK_50);
      #2;
   endtask

   task automatic idle();
      step(0, 0, 0, 4'd0, 1);
   endtask

   task automatic commit(input logic [3:0] d);
      step(0, 0, 1, d, 1);
   endtask

   initial begin
      // 1: reset, +123
      step(0, 0, 0, 4'd0, 0);
      cmp("lit_rst_hex0", 12'(HEX0), 12'(7'b1000000));
      cmp("lit_rst_hex3", 12'(HEX3), 12'(BLK));
      cmp("lit_rst_track", 12'(track_inp), 12'd0);
      idle();
      step(1, 0, 0, 4'd0, 1);
      cmp("lit_t1_track1", 12'(track_inp), 12'd1);
      commit(4'd3);
      cmp("lit_t1_track2", 12'(track_inp), 12'd2);
      commit(4'd2);
      cmp("lit_t1_track3", 12'(track_inp), 12'd3);
      commit(4'd1);
      cmp("lit_t1_track0", 12'(track_inp), 12'd0);
      cmp("lit_t1_value", value_out, 12'h123);
      cmp("lit_t1_valid", 12'(value_valid), 12'd1);
      cmp("lit_t1_hex2", 12'(HEX2), 12'(7'b1111001));
      cmp("lit_t1_hex1", 12'(HEX1), 12'(7'b0100100));
      cmp("lit_t1_hex0", 12'(HEX0), 12'(7'b0110000));
      cmp("lit_t1_hex3", 12'(HEX3), 12'(BLK));
      idle();

      // 2: negative, 5 then 7, hundreds flashes
      step(1, 1, 0, 4'd0, 1);
      commit(4'd5);
      commit(4'd7);
      cmp("lit_t2_hex2_lit0", 12'(HEX2), 12'(7'b1000000));
      for (int k = 1; k <= 40; k++) begin
         idle();
         cmp("lit_t2_hex2", 12'(HEX2), ((k / 4) % 2 == 0) ? 12'(7'b1000000) : 12'(BLK));
         cmp("lit_t2_hex0", 12'(HEX0), 12'(7'b0010010));
         cmp("lit_t2_hex1", 12'(HEX1), 12'(7'b1111000));
         cmp("lit_t2_hex3", 12'(HEX3), 12'(MIN));
      end

      // 3: complete 875, restart, enter 440
      commit(4'd8);
      cmp("lit_t3_value875", value_out, 12'h875);
      idle();
      step(1, 0, 0, 4'd0, 1);
      cmp("lit_t3_value0", value_out, 12'h000);
      cmp("lit_t3_valid0", 12'(value_valid), 12'd0);
      cmp("lit_t3_track1", 12'(track_inp), 12'd1);
      commit(4'd0);
      commit(4'd4);
      commit(4'd4);
      cmp("lit_t3_value440", value_out, 12'h440);

      // 4: rejected digit in TENS
      step(1, 0, 0, 4'd0, 1);
      commit(4'd1);
      commit(4'hB);
      cmp("lit_t4_err1", 12'(digit_err), 12'd1);
      cmp("lit_t4_value", value_out, 12'h001);
      cmp("lit_t4_track", 12'(track_inp), 12'd2);
      idle();
      cmp("lit_t4_err0", 12'(digit_err), 12'd0);
      commit(4'd6);
      cmp("lit_t4_value61", value_out, 12'h061);
      cmp("lit_t4_track3", 12'(track_inp), 12'd3);

      // 5: start and digit_we together in HUNS
      step(1, 0, 1, 4'd9, 1);
      cmp("lit_t5_track", 12'(track_inp), 12'd1);
      cmp("lit_t5_value", value_out, 12'h000);
      idle();
      cmp("lit_t5_value2", value_out, 12'h000);

      // 6: reset mid-entry in TENS, then digit_we in IDLE
      commit(4'd2);
      step(0, 0, 0, 4'd0, 0);
      cmp("lit_t6_track", 12'(track_inp), 12'd0);
      cmp("lit_t6_value", value_out, 12'h000);
      cmp("lit_t6_hex0", 12'(HEX0), 12'(7'b1000000));
      commit(4'd5);
      cmp("lit_t6_idle_value", value_out, 12'h000);
      cmp("lit_t6_idle_track", 12'(track_inp), 12'd0);

      // random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         step(($urandom_range(0, 15) == 0), 1'($urandom), ($urandom_range(0, 3) == 0),
              4'($urandom_range(0, 15)), ($urandom_range(0, 199) != 0));
      end
      idle();
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
